// File: rtl/fpu_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// fpu_regfile_scoreboard
//
// Floating-point register file with a pending-write scoreboard and the FCSR
// (rounding mode + sticky exception flags).
//
// Ports
//   clk, n_rst          : clock (rising edge), asynchronous active-low reset
//   rs_addr / rs_data   : NUM_RD combinational read ports (packed, port i at
//                         [i*AW +: AW] / [i*DATA_W +: DATA_W]), with bypass
//   rs_busy             : per-port pending bit of the addressed register
//   issue_en/rd/ok      : mark a destination pending; refused on WAW hazard
//   wb_en/rd/data/flags : FPU result writeback (highest write priority)
//   ld_en/rd/data/ready : FLW load write; accepted only when wb is idle
//   csr_we/csr_wdata    : FCSR write {frm[2:0], fflags[4:0]}
//   frm, fflags         : current rounding mode and accumulated flags
//   frm_illegal         : frm holds a reserved encoding (101/110/111)
// -----------------------------------------------------------------------------
module fpu_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 3,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*DATA_W-1:0] rs_data,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_rd,
    output logic                     issue_ok,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [4:0]               wb_flags,
    input  logic                     ld_en,
    input  logic [AW-1:0]            ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    input  logic                     csr_we,
    input  logic [7:0]               csr_wdata,
    output logic [2:0]               frm,
    output logic [4:0]               fflags,
    output logic                     frm_illegal
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  reg_hit;
    logic [2:0]        frm_q;
    logic [2:0]        frm_d;
    logic [4:0]        fflags_q;
    logic [4:0]        fflags_d;

    // Single physical write port: writeback wins, load is held off.
    logic              wr_en;
    logic [AW-1:0]     wr_rd;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_en   = wb_en | ld_en;
        wr_rd   = wb_en ? wb_rd   : ld_rd;
        wr_data = wb_en ? wb_data : ld_data;
    end

    assign ld_ready = ld_en & ~wb_en;

    // An issue colliding with a same-cycle write to its destination is
    // refused, so set and clear of one busy bit never coincide.
    assign issue_ok = issue_en & ~busy_q[issue_rd] & ~(wr_en && (wr_rd == issue_rd));

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            assign reg_hit[gi] = wr_en && (wr_rd == AW'(gi));
            assign busy_d[gi]  = (busy_q[gi] & ~reg_hit[gi])
                               | (issue_ok && (issue_rd == AW'(gi)));

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    regs_q[gi] <= '0;
                end else if (reg_hit[gi]) begin
                    regs_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports forward the write accepted this cycle, and report the
    // register as no longer pending when that write is clearing it.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] rd_addr;
            logic          rd_hit;
            assign rd_addr = rs_addr[gi*AW +: AW];
            assign rd_hit  = wr_en && (wr_rd == rd_addr);
            assign rs_data[gi*DATA_W +: DATA_W] = rd_hit ? wr_data : regs_q[rd_addr];
            assign rs_busy[gi] = busy_q[rd_addr] & ~rd_hit;
        end
    endgenerate

    // FCSR: a CSR write and a writeback's flags in the same cycle merge.
    always_comb begin
        frm_d    = csr_we ? csr_wdata[7:5] : frm_q;
        fflags_d = (csr_we ? csr_wdata[4:0] : fflags_q) | (wb_en ? wb_flags : 5'b0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frm_q    <= 3'b000;
            fflags_q <= 5'b00000;
        end else begin
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
        end
    end

    assign frm         = frm_q;
    assign fflags      = fflags_q;
    assign frm_illegal = frm_q[2] & (frm_q[1] | frm_q[0]);

endmodule

// File: tb/tb_fpu_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fpu_regfile_scoreboard
//
// Directed bench for fpu_regfile_scoreboard: a default 32x32, 3-read-port
// instance plus a 64-bit, 16-entry, 2-read-port instance. Inputs change 1 ns
// after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fpu_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;

    // Default instance (DATA_W=32, NREGS=32, NUM_RD=3)
    logic [14:0] rs_addr;
    logic [95:0] rs_data;
    logic [2:0]  rs_busy;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        issue_ok;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_flags;
    logic        ld_en;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        csr_we;
    logic [7:0]  csr_wdata;
    logic [2:0]  frm;
    logic [4:0]  fflags;
    logic        frm_illegal;

    // Wide instance (DATA_W=64, NREGS=16, NUM_RD=2)
    logic [7:0]   rs_addr64;
    logic [127:0] rs_data64;
    logic [1:0]   rs_busy64;
    logic         issue_en64;
    logic [3:0]   issue_rd64;
    logic         issue_ok64;
    logic         wb_en64;
    logic [3:0]   wb_rd64;
    logic [63:0]  wb_data64;
    logic [4:0]   wb_flags64;
    logic         ld_en64;
    logic [3:0]   ld_rd64;
    logic [63:0]  ld_data64;
    logic         ld_ready64;
    logic         csr_we64;
    logic [7:0]   csr_wdata64;
    logic [2:0]   frm64;
    logic [4:0]   fflags64;
    logic         frm_illegal64;

    fpu_regfile_scoreboard u_dut (
        .clk(clk), .n_rst(n_rst),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
        .ld_en(ld_en), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .csr_we(csr_we), .csr_wdata(csr_wdata),
        .frm(frm), .fflags(fflags), .frm_illegal(frm_illegal)
    );

    fpu_regfile_scoreboard #(.DATA_W(64), .NREGS(16), .NUM_RD(2)) u_dut64 (
        .clk(clk), .n_rst(n_rst),
        .rs_addr(rs_addr64), .rs_data(rs_data64), .rs_busy(rs_busy64),
        .issue_en(issue_en64), .issue_rd(issue_rd64), .issue_ok(issue_ok64),
        .wb_en(wb_en64), .wb_rd(wb_rd64), .wb_data(wb_data64), .wb_flags(wb_flags64),
        .ld_en(ld_en64), .ld_rd(ld_rd64), .ld_data(ld_data64), .ld_ready(ld_ready64),
        .csr_we(csr_we64), .csr_wdata(csr_wdata64),
        .frm(frm64), .fflags(fflags64), .frm_illegal(frm_illegal64)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_addr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        rs_addr = {a2, a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        rs_addr = '0; issue_en = 0; issue_rd = '0;
        wb_en = 0; wb_rd = '0; wb_data = '0; wb_flags = '0;
        ld_en = 0; ld_rd = '0; ld_data = '0;
        csr_we = 0; csr_wdata = '0;
        rs_addr64 = '0; issue_en64 = 0; issue_rd64 = '0;
        wb_en64 = 0; wb_rd64 = '0; wb_data64 = '0; wb_flags64 = '0;
        ld_en64 = 0; ld_rd64 = '0; ld_data64 = '0;
        csr_we64 = 0; csr_wdata64 = '0;

        #12 n_rst = 1'b1;
        #1;
        check("reset_frm",    64'(frm), 64'h0);
        check("reset_fflags", 64'(fflags), 64'h0);
        check("reset_busy",   64'(rs_busy), 64'h0);
        check("reset_rd64_15", rs_data64[63:0], 64'h0);

        // Load reg 5, issue reg 2; load data bypasses to port 0.
        next_cycle();
        set_addr(5'd5, 5'd2, 5'd0);
        ld_en = 1; ld_rd = 5'd5; ld_data = 32'h3F800000;
        issue_en = 1; issue_rd = 5'd2;
        #1;
        check("ld_ready_idle", 64'(ld_ready), 64'h1);
        check("issue_ok_r2",   64'(issue_ok), 64'h1);
        check("ld_bypass_r5",  64'(rs_data[31:0]), 64'h3F800000);

        // Writeback with a flag to reg 6.
        next_cycle();
        ld_en = 0; issue_en = 0;
        wb_en = 1; wb_rd = 5'd6; wb_data = 32'h1; wb_flags = 5'b00010;
        next_cycle();
        wb_en = 0; wb_flags = '0;
        #1;
        check("r5_stored",  64'(rs_data[31:0]), 64'h3F800000);
        check("r2_busy",    64'(rs_busy[1]), 64'h1);
        check("fflags_pre", 64'(fflags), 64'h02);
        // Asynchronous reset pulse in the middle of the cycle.
        #1 n_rst = 1'b0;
        #1;
        check("rst_r5",     64'(rs_data[31:0]), 64'h0);
        check("rst_busy",   64'(rs_busy), 64'h0);
        check("rst_fflags", 64'(fflags), 64'h0);
        check("rst_frm",    64'(frm), 64'h0);
        #1 n_rst = 1'b1;

        // Scoreboard: issue 7, busy visible next cycle, re-issue refused.
        next_cycle();
        set_addr(5'd7, 5'd0, 5'd0);
        issue_en = 1; issue_rd = 5'd7;
        #1;
        check("issue7_ok",       64'(issue_ok), 64'h1);
        check("issue7_busy_now", 64'(rs_busy[0]), 64'h0);
        next_cycle();
        check("issue7_busy_next", 64'(rs_busy[0]), 64'h1);
        check("reissue7_refused", 64'(issue_ok), 64'h0);
        next_cycle();
        issue_en = 0;
        wb_en = 1; wb_rd = 5'd7; wb_data = 32'h40490FDB;
        #1;
        check("wb7_bypass",   64'(rs_data[31:0]), 64'h40490FDB);
        check("wb7_busy_clr", 64'(rs_busy[0]), 64'h0);
        next_cycle();
        wb_en = 0;
        #1;
        check("r7_stored", 64'(rs_data[31:0]), 64'h40490FDB);
        check("r7_idle",   64'(rs_busy[0]), 64'h0);

        // Arbitration: wb (reg 3) beats ld (reg 4); ld goes next cycle.
        set_addr(5'd3, 5'd4, 5'd0);
        wb_en = 1; wb_rd = 5'd3; wb_data = 32'h11111111;
        ld_en = 1; ld_rd = 5'd4; ld_data = 32'h22222222;
        #1;
        check("arb_ld_refused", 64'(ld_ready), 64'h0);
        check("arb_r3_bypass",  64'(rs_data[31:0]), 64'h11111111);
        check("arb_r4_nobyp",   64'(rs_data[63:32]), 64'h0);
        next_cycle();
        wb_en = 0;
        #1;
        check("arb_ld_ready", 64'(ld_ready), 64'h1);
        check("arb_r4_bypass", 64'(rs_data[63:32]), 64'h22222222);
        next_cycle();
        ld_en = 0;
        #1;
        check("arb_r3", 64'(rs_data[31:0]), 64'h11111111);
        check("arb_r4", 64'(rs_data[63:32]), 64'h22222222);

        // Same-register race on reg 9.
        set_addr(5'd9, 5'd0, 5'd0);
        issue_en = 1; issue_rd = 5'd9;
        #1;
        check("race_first_issue", 64'(issue_ok), 64'h1);
        next_cycle();
        wb_en = 1; wb_rd = 5'd9; wb_data = 32'hC0000000;
        #1;
        check("race_issue_refused", 64'(issue_ok), 64'h0);
        check("race_busy_now",      64'(rs_busy[0]), 64'h0);
        next_cycle();
        wb_en = 0;
        #1;
        check("race_busy_after", 64'(rs_busy[0]), 64'h0);
        check("race_reissue_ok", 64'(issue_ok), 64'h1);
        next_cycle();
        issue_en = 0;
        #1;
        check("race_busy_set", 64'(rs_busy[0]), 64'h1);

        // Sticky flags and CSR/writeback merge.
        wb_en = 1; wb_rd = 5'd10; wb_data = 32'h0; wb_flags = 5'b00001;
        next_cycle();
        wb_flags = 5'b10000;
        next_cycle();
        wb_en = 0; wb_flags = '0;
        #1;
        check("flags_sticky", 64'(fflags), 64'h11);
        // A load must leave fflags alone.
        ld_en = 1; ld_rd = 5'd11; ld_data = 32'hFFFFFFFF;
        next_cycle();
        ld_en = 0;
        #1;
        check("flags_ld_noeffect", 64'(fflags), 64'h11);
        csr_we = 1; csr_wdata = 8'h00;
        wb_en = 1; wb_rd = 5'd12; wb_flags = 5'b00100;
        next_cycle();
        csr_we = 0; wb_en = 0; wb_flags = '0;
        #1;
        check("flags_csr_merge", 64'(fflags), 64'h04);

        // Rounding mode.
        csr_we = 1; csr_wdata = 8'b101_00000;
        next_cycle();
        csr_we = 0;
        #1;
        check("frm_101",         64'(frm), 64'h5);
        check("frm_101_illegal", 64'(frm_illegal), 64'h1);
        check("frm_clr_fflags",  64'(fflags), 64'h0);
        csr_we = 1; csr_wdata = 8'b001_00000;
        next_cycle();
        csr_we = 0;
        #1;
        check("frm_001",       64'(frm), 64'h1);
        check("frm_001_legal", 64'(frm_illegal), 64'h0);

        // Wide instance: reg 15 written and read on both ports.
        rs_addr64 = {4'd15, 4'd15};
        wb_en64 = 1; wb_rd64 = 4'd15; wb_data64 = 64'h400921FB54442D18;
        #1;
        check("w64_bypass_p0", rs_data64[63:0],   64'h400921FB54442D18);
        check("w64_bypass_p1", rs_data64[127:64], 64'h400921FB54442D18);
        next_cycle();
        wb_en64 = 0;
        #1;
        check("w64_r15_p0", rs_data64[63:0],   64'h400921FB54442D18);
        check("w64_r15_p1", rs_data64[127:64], 64'h400921FB54442D18);
        rs_addr64 = {4'd15, 4'd0};
        #1;
        check("w64_r0_p0",  rs_data64[63:0], 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
